// File: rtl/my_logic_unit.sv
// Bitwise logic unit (AND/OR/XOR/NOT/NAND/NOR/XNOR/PASS) with registered result and CCR.
// Result after 1 cycle, N after 2, Z and out_valid after 3; holds result while out_ready is low.
module my_logic_unit #(
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_SIZE-1:0] a,
  input  logic [OP_SIZE-1:0] b,
  input  logic [2:0]         op,
  input  logic               cv_load,
  input  logic [1:0]         cv_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_SIZE-1:0] r,
  output logic [3:0]         ccr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_FLAG_N = 3'd2,
    S_FLAG_Z = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  logic [OP_SIZE-1:0] r_a;
  logic [OP_SIZE-1:0] r_b;
  logic [2:0]         r_op;
  logic [OP_SIZE-1:0] r_res;
  logic [1:0]         r_nz;
  logic [1:0]         r_cv;
  logic               r_out_valid;

  logic               w_accept;
  logic [OP_SIZE-1:0] w_f;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign r         = r_res;
  assign ccr       = {r_cv, r_nz};

  always_comb begin
    w_f = r_a;
    case (r_op)
      3'b000:  w_f = r_a & r_b;
      3'b001:  w_f = r_a | r_b;
      3'b010:  w_f = r_a ^ r_b;
      3'b011:  w_f = ~r_a;
      3'b100:  w_f = ~(r_a & r_b);
      3'b101:  w_f = ~(r_a | r_b);
      3'b110:  w_f = ~(r_a ^ r_b);
      default: w_f = r_a;
    endcase
  end

  // Operands are captured only on the accepting edge, so later input changes cannot disturb the op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_res       <= '0;
      r_nz        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) r_state <= S_CALC;
        end
        S_CALC: begin
          r_res   <= w_f;
          r_state <= S_FLAG_N;
        end
        S_FLAG_N: begin
          r_nz[1] <= r_res[OP_SIZE-1];
          r_state <= S_FLAG_Z;
        end
        S_FLAG_Z: begin
          r_nz[0]     <= (r_res == '0);
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= in_valid ? S_CALC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // C and V are owned by cv_load alone and may be written in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cv <= '0;
    end else if (cv_load) begin
      r_cv <= cv_in;
    end
  end

endmodule
